// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//   Turns CPU byte/half/word load-store requests into accesses on a
//   word-organised memory. Sub-word stores are done as read-merge-write.
//   Misaligned or illegal-size requests are answered with resp_err and
//   never touch memory.
//
// Ports
//   CLK, Reset            clock, async active-low reset
//   req_valid/req_ready   request handshake (ready only when idle)
//   req_write             1 = store, 0 = load
//   req_size              00 byte, 01 half, 10 word, 11 illegal
//   req_sign              load sign-extension select
//   req_addr, req_wdata   byte address, right-aligned store data
//   resp_valid            one-cycle completion pulse (no backpressure)
//   resp_rdata, resp_err  extended load data, error flag
//   DataR, DataW          memory read / write enables
//   DAdd                  word index {2'b00, addr[31:2]}
//   Datain                word written to memory (committed on negedge CLK)
//   Dataout               combinational memory read data
// ---------------------------------------------------------------------------
module mem_access_unit (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        DataR,
    output logic        DataW,
    output logic [31:0] DAdd,
    output logic [31:0] Datain,
    input  logic [31:0] Dataout
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MERGE,
        ST_WRITE,
        ST_DONE
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic [1:0]  size_q,  size_d;
    logic        sign_q,  sign_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q,   err_d;

    logic        req_err;
    logic [4:0]  lane_shift;
    logic [31:0] rd_shifted;
    logic [31:0] load_ext;
    logic [31:0] lane_mask;
    logic [31:0] merged_word;

    // Alignment/size check on the live request, evaluated at accept.
    assign req_err = (req_size == 2'b11)
                   | ((req_size == SZ_HALF) & req_addr[0])
                   | ((req_size == SZ_WORD) & (|req_addr[1:0]));

    // Byte offset within the word; for aligned halves addr[0]=0 so this
    // equals addr[1]*16, and for words it is zero.
    assign lane_shift = {addr_q[1:0], 3'b000};
    assign rd_shifted = Dataout >> lane_shift;

    always_comb begin
        unique case (size_q)
            SZ_BYTE: load_ext = {{24{sign_q & rd_shifted[7]}},  rd_shifted[7:0]};
            SZ_HALF: load_ext = {{16{sign_q & rd_shifted[15]}}, rd_shifted[15:0]};
            default: load_ext = rd_shifted;
        endcase
    end

    assign lane_mask   = ((size_q == SZ_BYTE) ? 32'h0000_00FF : 32'h0000_FFFF) << lane_shift;
    assign merged_word = (Dataout & ~lane_mask) | ((wdata_q << lane_shift) & lane_mask);

    // ---------------- state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // ---------------- next-state logic ----------------
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_err)                 state_d = ST_DONE;
                    else if (!req_write)         state_d = ST_LOAD;
                    else if (req_size == SZ_WORD) state_d = ST_WRITE;
                    else                         state_d = ST_MERGE;
                end
            end
            ST_LOAD:  state_d = ST_DONE;
            ST_MERGE: state_d = ST_WRITE;
            ST_WRITE: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            write_q <= 1'b0;
            size_q  <= 2'b00;
            sign_q  <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            merge_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            write_q <= write_d;
            size_q  <= size_d;
            sign_q  <= sign_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            merge_q <= merge_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        write_d = write_q;
        size_d  = size_q;
        sign_d  = sign_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        merge_d = merge_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    size_d  = req_size;
                    sign_d  = req_sign;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    err_d   = req_err;
                    // Stores and errors report zero data.
                    rdata_d = 32'h0;
                end
            end
            ST_LOAD:  rdata_d = write_q ? 32'h0 : load_ext;
            ST_MERGE: merge_d = merged_word;
            default:  ;
        endcase
    end

    // ---------------- outputs ----------------
    // Memory strobes decode straight from state_q, so the async reset of
    // state_q drops DataW immediately, before the memory's negedge commit.
    always_comb begin
        req_ready  = (state_q == ST_IDLE);
        DataR      = (state_q == ST_LOAD) || (state_q == ST_MERGE);
        DataW      = (state_q == ST_WRITE);
        DAdd       = 32'h0;
        Datain     = 32'h0;
        resp_valid = (state_q == ST_DONE);
        resp_err   = (state_q == ST_DONE) && err_q;
        resp_rdata = rdata_q;
        if (DataR || DataW) DAdd = {2'b00, addr_q[31:2]};
        if (DataW)          Datain = (size_q == SZ_WORD) ? wdata_q : merge_q;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have port CLK, input, 1: single clock; all state updates on posedge.
REQ-002 SHALL have port Reset, input, 1: asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL have port req_valid, input, 1: CPU access request present.
REQ-004 SHALL have port req_ready, output, 1: unit can accept a request.
REQ-005 SHALL have port req_write, input, 1: 1 = store, 0 = load.
REQ-006 SHALL have port req_size, input, 2: 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-007 SHALL have port req_sign, input, 1: loads only; 1 = sign-extend, 0 = zero-extend.
REQ-008 SHALL have port req_addr, input, 32: byte address.
REQ-009 SHALL have port req_wdata, input, 32: store data, right-aligned.
REQ-010 SHALL have port resp_valid, output, 1: one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata, output, 32: load result, extended to 32 bits.
REQ-012 SHALL have port resp_err, output, 1: misaligned or illegal access; valid with resp_valid.
REQ-013 SHALL have ports DataR and DataW, output, 1 each: word-memory read and write enables.
REQ-014 SHALL have port DAdd, output, 32: word index, equal to {2'b00, addr[31:2]}.
REQ-015 SHALL have port Datain, output, 32: word written to memory.
REQ-016 SHALL have port Dataout, input, 32: combinational memory read data; the memory commits writes on negedge CLK.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, MERGE, WRITE, DONE.
REQ-018 SHALL drive req_ready=1 only in IDLE; on posedge with req_valid&req_ready, SHALL latch write, size, sign, addr and wdata.
REQ-019 SHALL flag err for size=11, for size=01 with addr[0]=1, and for size=10 with addr[1:0]!=0; an err request SHALL go IDLE->DONE without asserting DataR or DataW.
REQ-020 SHALL route a legal load IDLE->LOAD->DONE; in LOAD, SHALL assert DataR=1 and capture the extracted, extended lane into resp_rdata at posedge.
REQ-021 SHALL route a word store IDLE->WRITE->DONE.
REQ-022 SHALL route a byte/half store IDLE->MERGE->WRITE->DONE; in MERGE, SHALL assert DataR=1 and register Dataout with only the addressed lane replaced by req_wdata low bits.
REQ-023 SHALL assert DataW=1 for exactly the WRITE cycle, with Datain holding the merged word, or the full wdata for a word store.
REQ-024 SHALL use little-endian lanes: byte at bits addr[1:0]*8+7..addr[1:0]*8; half at bits addr[1]*16+15..addr[1]*16.
REQ-025 SHALL assert resp_valid in DONE for one cycle, then return to IDLE; the response SHALL have no backpressure.
REQ-026 SHALL produce load resp_valid 2 cycles after the accept edge; word store 2; sub-word store 3; err 1.
REQ-027 SHALL hold resp_rdata=0 for stores and errors, and resp_err=0 for legal accesses.
REQ-028 SHALL hold DataR, DataW and DAdd at 0 when not in LOAD, MERGE or WRITE; DataR and DataW SHALL never both be 1.
REQ-029 SHALL ignore req_valid outside IDLE; a request SHALL be accepted at the earliest on the posedge after DONE.

Reset
REQ-030 SHALL, while Reset=0, force the FSM to IDLE and set resp_valid=0, resp_err=0, resp_rdata=0, DataR=0, DataW=0, DAdd=0, Datain=0 and all latched request fields to 0.
REQ-031 SHALL deassert DataW asynchronously on Reset falling, even mid-WRITE, so that no negedge commit follows the reset assertion.
REQ-032 SHALL discard any in-flight request on reset, produce no resp_valid for it, and set req_ready=1 on the first cycle after reset release.

Verification
REQ-033 SHALL verify that with mem[1]=0x8899AABB, a load with size=00, sign=1, addr=0x5 yields resp_rdata=0xFFFFFFAA and resp_err=0, 2 cycles after accept.
REQ-034 SHALL verify that with mem[1]=0x8899AABB, a store with size=01, addr=0x6, wdata=0x00001234 yields DataW for one cycle with Datain=0x1234AABB, mem[1]=0x1234AABB, and resp_valid 3 cycles after accept.
REQ-035 SHALL verify that a store with size=10, addr=0x8, wdata=0xDEADBEEF gives DAdd=2 and mem[2]=0xDEADBEEF, with no DataR pulse.
REQ-036 SHALL verify that a load with size=10, addr=0x2 yields resp_err=1 and resp_rdata=0 one cycle after accept, with DataR and DataW never asserted.
REQ-037 SHALL verify that Reset=0 asserted during WRITE, before the negedge, leaves mem unchanged, drops DataW immediately, and gives req_ready=1 with no resp_valid after release.
REQ-038 SHALL verify that back-to-back req_valid held high yields accepts no closer than every 3 cycles for loads, with req_ready=0 in LOAD and DONE.
